// File: rtl/ssp_int_ctrl.sv
// SSP interrupt controller: raw status (level-following or edge-latched W1C), mask and combined INTR.
// Optional SSP_INT_SYNC_EN builds a two-flop synchronizer in front of the input stage.
module ssp_int_ctrl #(
    parameter int unsigned        NUM_SRC  = 4,
    parameter logic [NUM_SRC-1:0] EDGE_SRC = NUM_SRC'(4'b0100)
) (
    input  logic               PCLK,
    input  logic               PRESETn,
    input  logic [NUM_SRC-1:0] SrcIn,
    input  logic               MaskWr,
    input  logic [NUM_SRC-1:0] MaskWdata,
    input  logic               ClrWr,
    input  logic [NUM_SRC-1:0] ClrWdata,
    output logic [NUM_SRC-1:0] RIS,
    output logic [NUM_SRC-1:0] IMSC,
    output logic [NUM_SRC-1:0] MIS,
    output logic               INTR
);

    logic [NUM_SRC-1:0] src_s;
    logic [NUM_SRC-1:0] src_q;
    logic [NUM_SRC-1:0] ris_q, ris_d;
    logic [NUM_SRC-1:0] imsc_q, imsc_d;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] clr;

`ifdef SSP_INT_SYNC_EN
    logic [NUM_SRC-1:0] sync1_q;
    logic [NUM_SRC-1:0] sync2_q;

    // Two-flop synchronizer for sources from another clock domain.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= SrcIn;
            sync2_q <= sync1_q;
        end
    end

    assign src_s = sync2_q;
`else
    assign src_s = SrcIn;
`endif

    // Edge sources: a new rising edge beats a simultaneous clear so no event is lost.
    always_comb begin
        rise   = src_s & ~src_q;
        clr    = {NUM_SRC{ClrWr}} & ClrWdata;
        ris_d  = (~EDGE_SRC & src_s) | (EDGE_SRC & (rise | (ris_q & ~clr)));
        imsc_d = imsc_q;
        if (MaskWr) begin
            imsc_d = MaskWdata;
        end
    end

    // src_q resets low so a source already high at reset release counts as an edge.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            src_q  <= '0;
            ris_q  <= '0;
            imsc_q <= '0;
        end else begin
            src_q  <= src_s;
            ris_q  <= ris_d;
            imsc_q <= imsc_d;
        end
    end

    assign RIS  = ris_q;
    assign IMSC = imsc_q;
    assign MIS  = ris_q & imsc_q;
    assign INTR = |(ris_q & imsc_q);

endmodule

// File: tb/tb_ssp_int_ctrl.sv
// Self-checking bench for ssp_int_ctrl: directed plan items plus random traffic against a behavioural model.
module tb_ssp_int_ctrl;

    localparam int unsigned  N    = 4;
    localparam logic [N-1:0] EDGE = 4'b0100;
`ifdef SSP_INT_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic         PCLK      = 1'b0;
    logic         PRESETn   = 1'b0;
    logic [N-1:0] SrcIn     = '0;
    logic         MaskWr    = 1'b0;
    logic [N-1:0] MaskWdata = '0;
    logic         ClrWr     = 1'b0;
    logic [N-1:0] ClrWdata  = '0;
    logic [N-1:0] RIS;
    logic [N-1:0] IMSC;
    logic [N-1:0] MIS;
    logic         INTR;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: latched status, mask, and the history of applied inputs
    logic [N-1:0] m_ris;
    logic [N-1:0] m_imsc;
    logic [N-1:0] m_prev;
    logic [N-1:0] samp[$];

    ssp_int_ctrl #(.NUM_SRC(N), .EDGE_SRC(EDGE)) dut (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .SrcIn    (SrcIn),
        .MaskWr   (MaskWr),
        .MaskWdata(MaskWdata),
        .ClrWr    (ClrWr),
        .ClrWdata (ClrWdata),
        .RIS      (RIS),
        .IMSC     (IMSC),
        .MIS      (MIS),
        .INTR     (INTR)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ris  = '0;
        m_imsc = '0;
        m_prev = '0;
        samp.delete();
    endtask

    // Input seen by the status logic is the value applied LAT edges ago (counting this one).
    task automatic model_edge();
        logic [N-1:0] eff;
        samp.push_back(SrcIn);
        eff = (samp.size() >= LAT) ? samp[samp.size() - LAT] : '0;
        if (samp.size() > LAT) void'(samp.pop_front());
        for (int i = 0; i < int'(N); i++) begin
            if (EDGE[i]) begin
                if (eff[i] && !m_prev[i])        m_ris[i] = 1'b1;
                else if (ClrWr && ClrWdata[i])   m_ris[i] = 1'b0;
            end else begin
                m_ris[i] = eff[i];
            end
        end
        if (MaskWr) m_imsc = MaskWdata;
        m_prev = eff;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".ris"},  32'(RIS),  32'(m_ris));
        check({tag, ".imsc"}, 32'(IMSC), 32'(m_imsc));
        check({tag, ".mis"},  32'(MIS),  32'(m_ris & m_imsc));
        check({tag, ".intr"}, 32'(INTR), 32'(|(m_ris & m_imsc)));
    endtask

    // One clock: model the edge, sample 1 time unit later, then drop one-cycle strobes.
    task automatic step(input string tag);
        @(posedge PCLK);
        model_edge();
        #1;
        compare_all(tag);
        MaskWr = 1'b0;
        ClrWr  = 1'b0;
    endtask

    task automatic run(input string tag, input int n);
        for (int k = 0; k < n; k++) step(tag);
    endtask

    initial begin
        model_reset();

        // Reset with all sources high: everything reads zero
        SrcIn = 4'b1111;
        #12;
        check("rst.ris",  32'(RIS),  32'h0);
        check("rst.imsc", 32'(IMSC), 32'h0);
        check("rst.mis",  32'(MIS),  32'h0);
        check("rst.intr", 32'(INTR), 32'h0);
        PRESETn = 1'b1;
        run("rel", LAT);
        check("rel.ris_all", 32'(RIS), 32'hf);
        check("rel.intr0",   32'(INTR), 32'h0);

        // Level path with an ignored clear during the pulse
        SrcIn = '0;
        ClrWr = 1'b1; ClrWdata = 4'b0100;
        MaskWr = 1'b1; MaskWdata = 4'b0001;
        step("lvl.setup");
        run("lvl.idle", LAT + 1);
        SrcIn[0] = 1'b1;
        step("lvl.p0");
        ClrWr = 1'b1; ClrWdata = 4'b0001;
        step("lvl.p1");
        step("lvl.p2");
        SrcIn[0] = 1'b0;
        run("lvl.tail", LAT + 2);
        check("lvl.intr_off", 32'(INTR), 32'h0);

        // Edge latch then clear
        MaskWr = 1'b1; MaskWdata = 4'b0100;
        SrcIn[2] = 1'b1;
        step("edg.pulse");
        SrcIn[2] = 1'b0;
        run("edg.hold", LAT + 3);
        check("edg.intr_held", 32'(INTR), 32'h1);
        ClrWr = 1'b1; ClrWdata = 4'b0100;
        step("edg.clr");
        check("edg.intr_clr", 32'(INTR), 32'h0);
        run("edg.post", 2);

        // Set/clear collision: clear lands on the edge that re-sets the bit
        SrcIn[2] = 1'b1;
        step("col.pre");
        SrcIn[2] = 1'b0;
        run("col.lat", LAT + 2);
        SrcIn[2] = 1'b1;
        run("col.wait", LAT - 1);
        ClrWr = 1'b1; ClrWdata = 4'b0100;
        step("col.hit");
        check("col.ris2", 32'(RIS[2]), 32'h1);
        check("col.intr", 32'(INTR),   32'h1);
        // Clearing while still high leaves it clear until a new edge
        ClrWr = 1'b1; ClrWdata = 4'b0100;
        step("col.clr_high");
        run("col.stay", 3);
        check("col.stay0", 32'(RIS[2]), 32'h0);
        SrcIn[2] = 1'b0;
        run("col.low", LAT + 1);

        // Mask dynamics with RIS = 0110
        MaskWr = 1'b1; MaskWdata = 4'b0000;
        SrcIn = 4'b0110;
        step("msk.a");
        SrcIn = 4'b0010;
        run("msk.b", LAT + 2);
        check("msk.ris",   32'(RIS),  32'h6);
        check("msk.intr0", 32'(INTR), 32'h0);
        MaskWr = 1'b1; MaskWdata = 4'b0010;
        step("msk.on");
        check("msk.mis",   32'(MIS),  32'h2);
        check("msk.intr1", 32'(INTR), 32'h1);
        MaskWr = 1'b1; MaskWdata = 4'b0000;
        step("msk.off");
        check("msk.intr2", 32'(INTR), 32'h0);
        check("msk.ris2",  32'(RIS),  32'h6);

        // Async reset between edges while INTR is high
        MaskWr = 1'b1; MaskWdata = 4'b0110;
        step("ar.arm");
        check("ar.intr_pre", 32'(INTR), 32'h1);
        #2;
        PRESETn = 1'b0;
        #1;
        check("ar.ris",  32'(RIS),  32'h0);
        check("ar.imsc", 32'(IMSC), 32'h0);
        check("ar.mis",  32'(MIS),  32'h0);
        check("ar.intr", 32'(INTR), 32'h0);
        SrcIn = '0;
        model_reset();
        @(negedge PCLK);
        PRESETn = 1'b1;
        MaskWr = 1'b1; MaskWdata = 4'b1111;
        run("ar.post", LAT + 3);
        check("ar.no_relatch", 32'(RIS), 32'h0);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            SrcIn = N'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                MaskWr = 1'b1; MaskWdata = N'($urandom);
            end
            if ($urandom_range(0, 2) == 0) begin
                ClrWr = 1'b1; ClrWdata = N'($urandom);
            end
            step("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout tests=%0d", n_tests);
        $fatal(1, "timeout");
    end

endmodule
